// File: rtl/xoodoo_rdi_gen_pkg.sv
// Shared constants, FSM encodings and lane helpers for the Xoodoo RDI generator.
// No ports: imported by the interface, the lane register and the top.
package xoodoo_rdi_gen_pkg;
  localparam int NL = 12;
  localparam int LW = 32;
  localparam int RDI_W = NL * LW;
  localparam int SEED_W = 64;
  localparam int CNT_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [31:0] LANE_CONST [NL] = '{
    32'h9E3779B9, 32'h7F4A7C15, 32'h85EBCA6B,
    32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1,
    32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09,
    32'h68E31DA4, 32'h1B873593, 32'hCC9E2D51
  };

  function automatic logic [31:0] xs32(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // A zero lane would lock xorshift at zero, so it falls back to
  // the lane constant.
  function automatic logic [31:0] seed_lane(
    input logic [SEED_W-1:0] s,
    input logic [3:0]        k
  );
    logic [31:0] hi;
    logic [31:0] v;
    hi = s[63:32];
    v = s[31:0]
      ^ ((hi << k) | (hi >> (6'd32 - 6'(k))))
      ^ LANE_CONST[k];
    return (v == 32'd0) ? LANE_CONST[k] : v;
  endfunction
endpackage

// File: rtl/xoodoo_rdi_gen_if.sv
// Seed and randomness handshake bundle for the Xoodoo RDI generator.
// slave: generator side; master: host/consumer side.
interface xoodoo_rdi_gen_if;
  import xoodoo_rdi_gen_pkg::*;

  logic              enable_i;
  logic [SEED_W-1:0] seed_i;
  logic              seed_valid_i;
  logic              seed_ready_o;
  logic [RDI_W-1:0]  rdi_o;
  logic              rdi_valid_o;
  logic              rdi_ready_i;
  logic [CNT_W-1:0]  word_cnt_o;

  modport slave (
    input  enable_i, seed_i, seed_valid_i, rdi_ready_i,
    output seed_ready_o, rdi_o, rdi_valid_o, word_cnt_o
  );

  modport master (
    output enable_i, seed_i, seed_valid_i, rdi_ready_i,
    input  seed_ready_o, rdi_o, rdi_valid_o, word_cnt_o
  );
endinterface

// File: rtl/xoodoo_rdi_gen_lane.sv
// One 32-bit xorshift32 lane: load has priority over step, else hold.
// Ports: clk_i, rst_ni, load_i, step_i, seed_i (load value), nxt_o (post-step value).
module xoodoo_rdi_gen_lane
  import xoodoo_rdi_gen_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [LW-1:0] seed_i,
  output logic [LW-1:0] nxt_o
);
  logic [LW-1:0] lane_q;
  logic [LW-1:0] lane_d;

  assign nxt_o = xs32(lane_q);

  always_comb begin
    lane_d = lane_q;
    if (load_i) lane_d = seed_i;
    else if (step_i) lane_d = nxt_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lane_q <= '0;
    else lane_q <= lane_d;
  end
endmodule

// File: rtl/xoodoo_rdi_gen.sv
// Fresh-randomness source for the masked Xoodoo round core: 12 xorshift32 lanes.
// Ports: clk_i, rst_ni, bus (seed/rdi handshakes, enable_i, word_cnt_o).
module xoodoo_rdi_gen
  import xoodoo_rdi_gen_pkg::*;
#(
  parameter int WARMUP = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  xoodoo_rdi_gen_if.slave        bus
);
  localparam int WW = $clog2(WARMUP + 1);

  logic [1:0]       state_q, state_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [RDI_W-1:0] rdi_q, rdi_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RDI_W-1:0] lanes_nx;
  logic             load, step;
  logic             seed_rdy, seed_hs, rdi_hs;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    xoodoo_rdi_gen_lane u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .step_i (step),
      .seed_i (seed_lane(bus.seed_i, 4'(k))),
      .nxt_o  (lanes_nx[LW*k +: LW])
    );
  end

  assign seed_rdy = (state_q == ST_IDLE) | (state_q == ST_RUN);
  assign seed_hs = bus.seed_valid_i & seed_rdy;
  assign rdi_hs = vld_q & bus.rdi_ready_i;

  assign bus.seed_ready_o = seed_rdy;
  assign bus.rdi_o = rdi_q;
  assign bus.rdi_valid_o = vld_q;
  assign bus.word_cnt_o = cnt_q;

  always_comb begin
    state_d = state_q;
    warm_d = warm_q;
    rdi_d = rdi_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    load = 1'b0;
    step = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (seed_hs) begin
          load = 1'b1;
          cnt_d = '0;
          warm_d = '0;
          state_d = ST_WARM;
        end else if (bus.enable_i) begin
          state_d = ST_FILL;
        end
      end
      (state_q == ST_WARM): begin
        step = 1'b1;
        warm_d = warm_q + WW'(1);
        if (warm_q == WW'(WARMUP - 1))
          state_d = bus.enable_i ? ST_FILL : ST_IDLE;
      end
      (state_q == ST_FILL): begin
        step = 1'b1;
        rdi_d = lanes_nx;
        vld_d = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        if (rdi_hs) cnt_d = cnt_q + CNT_W'(1);
        // Reseed wins: an untaken pending word is simply dropped.
        if (seed_hs) begin
          load = 1'b1;
          cnt_d = '0;
          warm_d = '0;
          vld_d = 1'b0;
          state_d = ST_WARM;
        end else if (rdi_hs) begin
          if (bus.enable_i) begin
            step = 1'b1;
            rdi_d = lanes_nx;
          end else begin
            // Lanes hold so a resume continues the same stream.
            vld_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      warm_q <= '0;
      rdi_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q <= warm_d;
      rdi_q <= rdi_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_xoodoo_rdi_gen.sv
// Self-checking bench for xoodoo_rdi_gen against a lane-array reference model.
// Drives the handshake interface; prints one CHECKS/ERRORS summary line.
module tb_xoodoo_rdi_gen;
  localparam int W = 16;
  localparam logic [31:0] TC [12] = '{
    32'h9E3779B9, 32'h7F4A7C15, 32'h85EBCA6B,
    32'hC2B2AE35, 32'h27D4EB2F, 32'h165667B1,
    32'hD3A2646C, 32'hFD7046C5, 32'hB55A4F09,
    32'h68E31DA4, 32'h1B873593, 32'hCC9E2D51
  };

  typedef struct {
    logic [63:0] seed;
    int          words;
    int          pct;
    logic        rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [31:0]  ml [12];
  logic [383:0] exp_word;
  int           exp_cnt;
  vec_t         vecs [4];

  xoodoo_rdi_gen_if bus ();

  xoodoo_rdi_gen #(.WARMUP(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [383:0] act,
                     input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic m_seed(input logic [63:0] s);
    logic [31:0] hi;
    logic [31:0] v;
    for (int k = 0; k < 12; k++) begin
      hi = s[63:32];
      for (int r = 0; r < k; r++) hi = {hi[30:0], hi[31]};
      v = s[31:0] ^ hi ^ TC[k];
      ml[k] = (v == 0) ? TC[k] : v;
    end
  endtask

  task automatic m_step(output logic [383:0] w);
    for (int k = 0; k < 12; k++) begin
      ml[k] = xs(ml[k]);
      w[32*k +: 32] = ml[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_load(input logic [63:0] s, input logic rdy);
    logic [383:0] d;
    chk("seed_ready_pre", 384'(bus.seed_ready_o), 384'd1);
    bus.seed_i = s;
    bus.seed_valid_i = 1'b1;
    bus.enable_i = 1'b1;
    bus.rdi_ready_i = rdy;
    tick();
    bus.seed_valid_i = 1'b0;
    bus.rdi_ready_i = 1'b0;
    m_seed(s);
    for (int i = 0; i < W; i++) m_step(d);
    m_step(exp_word);
    exp_cnt = 0;
    for (int n = 1; n < W + 2; n++) begin
      chk("warm_valid_low", 384'(bus.rdi_valid_o), 384'd0);
      chk("warm_seed_ready", 384'(bus.seed_ready_o), 384'd0);
      chk("warm_cnt_zero", 384'(bus.word_cnt_o), 384'd0);
      tick();
    end
    chk("first_valid", 384'(bus.rdi_valid_o), 384'd1);
    chk("first_word", bus.rdi_o, exp_word);
  endtask

  task automatic stream(input int n, input int pct);
    int got;
    int cyc;
    logic r;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 50 + 50) begin
      chk("run_valid", 384'(bus.rdi_valid_o), 384'd1);
      chk("run_word", bus.rdi_o, exp_word);
      chk("run_cnt", 384'(bus.word_cnt_o), 384'(exp_cnt));
      r = ($urandom_range(99) >= pct);
      bus.rdi_ready_i = r;
      tick();
      cyc++;
      if (r) begin
        got++;
        exp_cnt++;
        m_step(exp_word);
      end
    end
    bus.rdi_ready_i = 1'b0;
    if (got < n) chk("stream_timeout", 384'(got), 384'(n));
  endtask

  initial begin
    bus.enable_i = 1'b0;
    bus.seed_i = '0;
    bus.seed_valid_i = 1'b0;
    bus.rdi_ready_i = 1'b0;
    exp_cnt = 0;
    exp_word = '0;

    vecs[0] = '{64'h0, 100, 0, 1'b0};
    vecs[1] = '{{32'h0, TC[3]}, 40, 30, 1'b1};
    vecs[2] = '{{$urandom, $urandom}, 60, 50, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 30, 80, 1'b1};

    repeat (2) tick();
    chk("rst_valid", 384'(bus.rdi_valid_o), 384'd0);
    chk("rst_rdi", bus.rdi_o, 384'd0);
    chk("rst_cnt", 384'(bus.word_cnt_o), 384'd0);
    chk("rst_seed_ready", 384'(bus.seed_ready_o), 384'd1);
    rst_ni = 1'b1;
    tick();
    chk("rel_seed_ready", 384'(bus.seed_ready_o), 384'd1);

    for (int v = 0; v < 4; v++) begin
      seed_load(vecs[v].seed, vecs[v].rdy);
      stream(vecs[v].words, vecs[v].pct);
      chk("vec_word_cnt", 384'(bus.word_cnt_o), 384'(vecs[v].words));
    end

    bus.enable_i = 1'b0;
    repeat (2) begin
      tick();
      chk("dis_hold_valid", 384'(bus.rdi_valid_o), 384'd1);
      chk("dis_hold_word", bus.rdi_o, exp_word);
    end
    bus.rdi_ready_i = 1'b1;
    tick();
    bus.rdi_ready_i = 1'b0;
    exp_cnt++;
    chk("dis_valid_low", 384'(bus.rdi_valid_o), 384'd0);
    chk("dis_cnt", 384'(bus.word_cnt_o), 384'(exp_cnt));
    chk("dis_idle_ready", 384'(bus.seed_ready_o), 384'd1);
    tick();
    chk("dis_stay_low", 384'(bus.rdi_valid_o), 384'd0);
    bus.enable_i = 1'b1;
    tick();
    chk("resume_fill_low", 384'(bus.rdi_valid_o), 384'd0);
    tick();
    m_step(exp_word);
    chk("resume_valid", 384'(bus.rdi_valid_o), 384'd1);
    chk("resume_word", bus.rdi_o, exp_word);
    chk("resume_cnt", 384'(bus.word_cnt_o), 384'(exp_cnt));
    stream(20, 40);

    bus.rdi_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    bus.enable_i = 1'b0;
    bus.rdi_ready_i = 1'b0;
    #1;
    chk("arst_valid", 384'(bus.rdi_valid_o), 384'd0);
    chk("arst_rdi", bus.rdi_o, 384'd0);
    chk("arst_cnt", 384'(bus.word_cnt_o), 384'd0);
    chk("arst_seed_ready", 384'(bus.seed_ready_o), 384'd1);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    chk("arel_seed_ready", 384'(bus.seed_ready_o), 384'd1);
    chk("arel_valid", 384'(bus.rdi_valid_o), 384'd0);
    seed_load({$urandom, $urandom}, 1'b0);
    stream(30, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
